signal_conditioner: RTL and testbench



---
 rtl/signal_conditioner.sv | 108 ++++++++++
 tb/tb_signal_conditioner.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_conditioner.sv
// signal_conditioner: pad synchroniser, glitch filter and edge strobes.
// Define SIGNAL_COND_TIMEOUT_EN to build the no_signal timeout counter.
module signal_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_BITS  = 4,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   signal_in,
    input  logic                   enable,
    input  logic [FILTER_BITS-1:0] filter_len,
    input  logic                   glitch_clear,
    output logic                   signal_out,
    output logic                   rise,
    output logic                   fall,
    output logic [7:0]             glitch_count,
    output logic                   no_signal
);

    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [NSYNC-1:0]       r_sync;
    logic [FILTER_BITS-1:0] r_cnt;
    logic                   r_out;
    logic                   r_rise;
    logic                   r_fall;
    logic [7:0]             r_gcnt;

    logic w_sync_q;
    logic w_mismatch;
    logic w_accept;
    logic w_glitch;
    logic w_rise_evt;

    assign w_sync_q   = r_sync[NSYNC-1];
    assign w_mismatch = w_sync_q != r_out;
    // filter_len is compared live so lowering it mid-run accepts at once
    assign w_accept   = enable && w_mismatch && (r_cnt >= filter_len);
    assign w_glitch   = enable && !w_mismatch && (r_cnt != '0);
    assign w_rise_evt = w_accept && w_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NSYNC-2:0], signal_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out  <= 1'b0;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_rise_evt;
            r_fall <= w_accept && !w_sync_q;
            if (enable) begin
                if (!w_mismatch) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_out <= w_sync_q;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gcnt <= '0;
        end else if (glitch_clear) begin
            r_gcnt <= '0;
        end else if (w_glitch && (r_gcnt != 8'hFF)) begin
            r_gcnt <= r_gcnt + 8'd1;
        end
    end

    assign signal_out   = r_out;
    assign rise         = r_rise;
    assign fall         = r_fall;
    assign glitch_count = r_gcnt;

`ifdef SIGNAL_COND_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] r_tmo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
        end else if (enable) begin
            if (w_rise_evt) begin
                r_tmo <= '0;
            end else if (r_tmo != '1) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign no_signal = &r_tmo;
`else
    assign no_signal = (TIMEOUT_BITS < 0);
`endif

endmodule

// File: tb/tb_signal_conditioner.sv
// tb_signal_conditioner: directed and random checks of signal_conditioner
// against a behavioural model of the filtering rules.
module tb_signal_conditioner;

    localparam int SYNC = 2;
    localparam int FB   = 4;
    localparam int TB   = 4;
    localparam int TMAX = (1 << TB) - 1;

`ifdef SIGNAL_COND_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          signal_in = 1'b0;
    logic          enable = 1'b0;
    logic [FB-1:0] filter_len = '0;
    logic          glitch_clear = 1'b0;
    logic          signal_out;
    logic          rise;
    logic          fall;
    logic [7:0]    glitch_count;
    logic          no_signal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    signal_conditioner #(
        .SYNC_STAGES (SYNC),
        .FILTER_BITS (FB),
        .TIMEOUT_BITS(TB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .signal_in   (signal_in),
        .enable      (enable),
        .filter_len  (filter_len),
        .glitch_clear(glitch_clear),
        .signal_out  (signal_out),
        .rise        (rise),
        .fall        (fall),
        .glitch_count(glitch_count),
        .no_signal   (no_signal)
    );

    // Model: run = disagreeing samples seen since last decision,
    // since = enabled cycles since the last accepted rise.
    typedef struct {
        bit out;
        int run;
        int gc;
        int since;
        bit rise;
        bit fall;
    } mstate_t;

    mstate_t         m;
    logic [SYNC-1:0] m_hist;

    function automatic mstate_t model_next(mstate_t c, bit s);
        mstate_t n;
        n = c;
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (enable) begin
            if (s == c.out) begin
                if (c.run > 0) n.gc = (c.gc < 255) ? c.gc + 1 : 255;
                n.run = 0;
            end else if (c.run >= int'(filter_len)) begin
                n.out  = s;
                n.run  = 0;
                n.rise = s;
                n.fall = !s;
            end else begin
                n.run = c.run + 1;
            end
            n.since = n.rise ? 0 : ((c.since < TMAX) ? c.since + 1 : TMAX);
        end
        if (glitch_clear) n.gc = 0;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m      <= '{default: 0};
            m_hist <= '0;
        end else begin
            m      <= model_next(m, m_hist[SYNC-1]);
            m_hist <= {m_hist[SYNC-2:0], signal_in};
        end
    end

    function automatic bit exp_nosig();
        return TO_ON && (m.since >= TMAX);
    endfunction

    task automatic settle_low();
        signal_in    = 1'b0;
        filter_len   = '0;
        enable       = 1'b1;
        glitch_clear = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        signal_in    = 1'b1;
        enable       = 1'b1;
        filter_len   = '0;
        glitch_clear = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({signal_out, rise, fall, no_signal} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_outs: got %b want 0000",
                     {signal_out, rise, fall, no_signal});
        end
        n_checks++;
        if (glitch_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_gcnt: got %0d want 0", glitch_count);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (signal_out !== (k >= 2) || rise !== (k == 2) || fall !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_rise E%0d: got out=%b rise=%b fall=%b want %b %b 0",
                         k, signal_out, rise, fall, k >= 2, k == 2);
            end
        end
        n_checks++;
        if (glitch_count !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_rise_gcnt: got %0d want 0", glitch_count);
        end
    endtask

    task automatic test_glitch();
        int  g0;
        bit  moved;
        settle_low();
        filter_len = 4'd3;
        g0         = m.gc;
        moved      = 1'b0;
        signal_in  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 2) signal_in = 1'b0;
            if (signal_out || rise || fall) moved = 1'b1;
        end
        n_checks++;
        if (moved !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch3_no_edge: got change=%b want 0", moved);
        end
        n_checks++;
        if (glitch_count !== 8'(g0 + 1)) begin
            n_errors++;
            $display("FAIL glitch3_count: got %0d want %0d", glitch_count, g0 + 1);
        end
        signal_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 3) signal_in = 1'b0;
            n_checks++;
            if (rise !== (k == 5) || fall !== (k == 9)) begin
                n_errors++;
                $display("FAIL pulse4 E%0d: got rise=%b fall=%b want %b %b",
                         k, rise, fall, k == 5, k == 9);
            end
        end
        n_checks++;
        if (glitch_count !== 8'(g0 + 1)) begin
            n_errors++;
            $display("FAIL pulse4_count: got %0d want %0d", glitch_count, g0 + 1);
        end
    endtask

    task automatic test_saturation();
        settle_low();
        filter_len = 4'd5;
        repeat (300) begin
            signal_in = 1'b1;
            repeat (2) @(negedge clk);
            signal_in = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (glitch_count !== 8'd255 || glitch_count !== 8'(m.gc)) begin
            n_errors++;
            $display("FAIL sat_count: got %0d want 255 (model %0d)",
                     glitch_count, m.gc);
        end
        signal_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        signal_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        glitch_clear = 1'b1;
        @(negedge clk);
        glitch_clear = 1'b0;
        n_checks++;
        if (glitch_count !== 8'd0) begin
            n_errors++;
            $display("FAIL clear_vs_inc: got %0d want 0", glitch_count);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (glitch_count !== 8'd0) begin
            n_errors++;
            $display("FAIL clear_hold: got %0d want 0", glitch_count);
        end
    endtask

    task automatic test_enable_freeze();
        int g0;
        settle_low();
        filter_len = 4'd6;
        g0         = m.gc;
        signal_in  = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 14; k++) begin
            signal_in = (k < 10) ? k[0] : 1'b1;
            @(negedge clk);
            n_checks++;
            if ({signal_out, rise, fall} !== 3'b000 || glitch_count !== 8'(g0)) begin
                n_errors++;
                $display("FAIL freeze c%0d: got out=%b rise=%b fall=%b gc=%0d want 0 0 0 %0d",
                         k, signal_out, rise, fall, glitch_count, g0);
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (rise !== (k == 4) || fall !== 1'b0) begin
                n_errors++;
                $display("FAIL resume R%0d: got rise=%b fall=%b want %b 0",
                         k + 1, rise, fall, k == 4);
            end
        end
        n_checks++;
        if (glitch_count !== 8'(g0)) begin
            n_errors++;
            $display("FAIL resume_gcnt: got %0d want %0d", glitch_count, g0);
        end
    endtask

    task automatic test_live_len();
        settle_low();
        filter_len = 4'd8;
        signal_in  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 6) filter_len = 4'd2;
            n_checks++;
            if (rise !== (k == 7) || signal_out !== (k >= 7)) begin
                n_errors++;
                $display("FAIL live_len E%0d: got rise=%b out=%b want %b %b",
                         k, rise, signal_out, k == 7, k >= 7);
            end
        end
    endtask

    task automatic test_random();
        int tp;
        for (int i = 0; i < 2000; i++) begin
            tp = ((i / 100) % 3 == 0) ? 2 : (((i / 100) % 3 == 1) ? 5 : 60);
            if ($urandom_range(0, tp - 1) == 0) signal_in = ~signal_in;
            if ($urandom_range(0, 63) == 0) filter_len = FB'($urandom_range(0, 5));
            enable       = ($urandom_range(0, 15) != 0);
            glitch_clear = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            n_checks++;
            if (signal_out !== m.out || rise !== m.rise || fall !== m.fall) begin
                n_errors++;
                $display("FAIL rnd_level c%0d: got out=%b rise=%b fall=%b want %b %b %b",
                         i, signal_out, rise, fall, m.out, m.rise, m.fall);
            end
            n_checks++;
            if (glitch_count !== 8'(m.gc)) begin
                n_errors++;
                $display("FAIL rnd_gcnt c%0d: got %0d want %0d", i, glitch_count, m.gc);
            end
            n_checks++;
            if (no_signal !== exp_nosig()) begin
                n_errors++;
                $display("FAIL rnd_nosig c%0d: got %b want %b", i, no_signal, exp_nosig());
            end
            n_checks++;
            if (rise && fall) begin
                n_errors++;
                $display("FAIL rnd_exclusive c%0d: got rise=1 fall=1 want not both", i);
            end
        end
        glitch_clear = 1'b0;
        enable       = 1'b1;
    endtask

    task automatic test_timeout();
        reset_n      = 1'b0;
        signal_in    = 1'b0;
        enable       = 1'b1;
        filter_len   = '0;
        glitch_clear = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n_checks++;
            if (no_signal !== (TO_ON && k >= 14)) begin
                n_errors++;
                $display("FAIL tmo_idle E%0d: got %b want %b",
                         k, no_signal, TO_ON && k >= 14);
            end
        end
        signal_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rise !== (k == 2) || no_signal !== (TO_ON && k < 2)) begin
                n_errors++;
                $display("FAIL tmo_rise F%0d: got rise=%b nosig=%b want %b %b",
                         k, rise, no_signal, k == 2, TO_ON && k < 2);
            end
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_checks++;
            if (no_signal !== (TO_ON && k >= 15) || rise !== 1'b0) begin
                n_errors++;
                $display("FAIL tmo_rearm +%0d: got nosig=%b rise=%b want %b 0",
                         k, no_signal, rise, TO_ON && k >= 15);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_saturation();
        test_enable_freeze();
        test_live_len();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
